// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution window feeder.
package conv_pkg;

    localparam int MAP_W     = 22;
    localparam int K         = 5;
    localparam int OUT_W     = MAP_W - K + 1;
    localparam int NUM_OUT   = OUT_W * OUT_W;
    localparam int NUM_PAIRS = NUM_OUT * K * K;
    localparam int MAP_SIZE  = MAP_W * MAP_W;
    localparam int NUM_WGT   = K * K;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;

    localparam int ADDR_W = $clog2(MAP_SIZE);
    localparam int KIDX_W = $clog2(NUM_WGT);
    localparam int RC_W   = $clog2(OUT_W);
    localparam int IJ_W   = $clog2(K);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Load and stream signals of the window feeder, seen from the upstream/consumer side (master) and the feeder (slave).
interface conv_window_feeder_if;
    import conv_pkg::*;

    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              k_wr;
    logic [KIDX_W-1:0] k_addr;
    logic [DATA_W-1:0] k_data;
    logic [DATA_W-1:0] map_out;
    logic [DATA_W-1:0] k_out;
    logic              ready;
    logic              done;

    modport master (
        output pix_in, pix_valid, k_wr, k_addr, k_data,
        input  map_out, k_out, ready, done
    );

    modport slave (
        input  pix_in, pix_valid, k_wr, k_addr, k_data,
        output map_out, k_out, ready, done
    );

endinterface

// File: rtl/fmap_ram.sv
// Single-port feature-map buffer: synchronous write, registered one-cycle read.
module fmap_ram
    import conv_pkg::*;
(
    input  logic              clk_in,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // NOTE: the array has no reset so it maps onto block RAM; every location is rewritten by each map load.
    logic [DATA_W-1:0] r_mem [0:MAP_SIZE-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk_in) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers one input map, then streams every KxK window as (pixel, weight) pairs, one per clock.
module conv_window_feeder
    import conv_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n,
    conv_window_feeder_if.slave  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [RC_W-1:0]   r_row;
    logic [RC_W-1:0]   r_col;
    logic [IJ_W-1:0]   r_ki;
    logic [IJ_W-1:0]   r_kj;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_k_q;
    logic [DATA_W-1:0] r_map_out;
    logic [DATA_W-1:0] r_k_out;
    logic              r_ready;
    logic              r_done;

    logic [DATA_W-1:0] r_wgt [0:NUM_WGT-1];

    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [KIDX_W-1:0] w_kidx;
    logic              w_ram_we;
    logic              w_wgt_we;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_last_pair;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rd_addr   = (ADDR_W'(r_row) + ADDR_W'(r_ki)) * ADDR_W'(MAP_W)
                    + ADDR_W'(r_col) + ADDR_W'(r_kj);
        w_kidx      = KIDX_W'(r_ki) * KIDX_W'(K) + KIDX_W'(r_kj);
        w_ram_we    = rst_n && (r_state == FILL) && bus.pix_valid;
        w_ram_addr  = (r_state == FILL) ? r_fill_cnt : w_rd_addr;
        w_wgt_we    = rst_n && bus.k_wr && (r_state != STREAM)
                    && (bus.k_addr < KIDX_W'(NUM_WGT));
        w_last_pair = (r_row == RC_W'(OUT_W - 1)) && (r_col == RC_W'(OUT_W - 1))
                    && (r_ki == IJ_W'(K - 1)) && (r_kj == IJ_W'(K - 1));
    end

    fmap_ram u_fmap_ram (
        .clk_in  (clk_in),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.pix_in),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk_in) begin
        if (w_wgt_we) begin
            r_wgt[bus.k_addr] <= bus.k_data;
        end
    end

    // The weight read is registered once so it lines up with the RAM read latency.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_ki       <= '0;
            r_kj       <= '0;
            r_rd_vld   <= 1'b0;
            r_k_q      <= '0;
            r_map_out  <= '0;
            r_k_out    <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_rd_vld <= 1'b0;

            case (r_state)
                FILL: begin
                    if (bus.pix_valid) begin
                        if (r_fill_cnt == ADDR_W'(MAP_SIZE - 1)) begin
                            r_fill_cnt <= '0;
                            r_state    <= STREAM;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                    end
                end

                STREAM: begin
                    r_rd_vld <= 1'b1;
                    r_k_q    <= r_wgt[w_kidx];
                    if (r_kj == IJ_W'(K - 1)) begin
                        r_kj <= '0;
                        if (r_ki == IJ_W'(K - 1)) begin
                            r_ki <= '0;
                            if (r_col == RC_W'(OUT_W - 1)) begin
                                r_col <= '0;
                                r_row <= (r_row == RC_W'(OUT_W - 1)) ? '0 : r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end else begin
                            r_ki <= r_ki + 1'b1;
                        end
                    end else begin
                        r_kj <= r_kj + 1'b1;
                    end
                    if (w_last_pair) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_state <= DONE;
                end

                default: begin
                    r_state <= FILL;
                end
            endcase

            // Output stage: a pair is presented the cycle after its read was issued.
            if (r_rd_vld) begin
                r_map_out <= w_ram_rdata;
                r_k_out   <= r_k_q;
                r_ready   <= 1'b0;
            end else begin
                r_ready <= 1'b1;
                if (r_state == DONE) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.map_out = r_map_out;
    assign bus.k_out   = r_k_out;
    assign bus.ready   = r_ready;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: loads ramp maps and checks the full streamed pair sequence.
module tb_conv_window_feeder;

    localparam int NPAIRS = 8100;
    localparam int NPIX   = 484;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    conv_window_feeder_if bus ();

    conv_window_feeder dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Window n/25 at (r,c) in raster order, tap (i,j) = n%25; pixel value equals its address.
    function automatic void exp_pair(input int n, output logic [15:0] em, output logic [15:0] ek);
        int o, k;
        o  = n / 25;
        k  = n % 25;
        em = 16'(((o / 18) + (k / 5)) * 22 + (o % 18) + (k % 5));
        ek = 16'(k + 1);
    endfunction

    task automatic do_reset(input string tag);
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.k_wr      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check({tag, "_ready"},   32'(bus.ready),   32'd1);
        check({tag, "_done"},    32'(bus.done),    32'd0);
        check({tag, "_map_out"}, 32'(bus.map_out), 32'd0);
        check({tag, "_k_out"},   32'(bus.k_out),   32'd0);
    endtask

    task automatic load_weights();
        for (int n = 0; n < 25; n++) begin
            bus.k_wr   = 1'b1;
            bus.k_addr = 5'(n);
            bus.k_data = 16'(n + 1);
            tick();
        end
        bus.k_wr   = 1'b1;
        bus.k_addr = 5'd27;
        bus.k_data = 16'h1000;
        tick();
        bus.k_wr = 1'b0;
    endtask

    // Returns right after the edge that accepts the last pixel.
    task automatic load_pixels(input bit gaps);
        for (int a = 0; a < NPIX; a++) begin
            if (gaps && a > 0) begin
                bus.pix_valid = 1'b0;
                bus.pix_in    = 16'h7FFF;
                tick();
                tick();
            end
            bus.pix_valid = 1'b1;
            bus.pix_in    = 16'(a);
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    // mode 0: plain; mode 1: stray pixels and weight write during stream; mode 2: reset at pair 1000.
    task automatic run_stream(input int mode, input string tag);
        int lows, nbad, first_bad, n7fff;
        logic [15:0] em, ek;
        lows = 0; nbad = 0; first_bad = -1; n7fff = 0;
        tick();
        check({tag, "_ready_t1"}, 32'(bus.ready), 32'd1);
        for (int n = 0; n < NPAIRS; n++) begin
            tick();
            bus.k_wr      = 1'b0;
            bus.pix_valid = 1'b0;
            exp_pair(n, em, ek);
            if (n == 0) check({tag, "_ready_t2"}, 32'(bus.ready), 32'd0);
            if (bus.ready === 1'b0) lows++;
            if (bus.map_out === 16'h7FFF) n7fff++;
            if (bus.map_out !== em || bus.k_out !== ek) begin
                nbad++;
                if (first_bad < 0) first_bad = n;
            end
            if (n < 50 || n >= NPAIRS - 25) begin
                check($sformatf("%s_map_%0d", tag, n), 32'(bus.map_out), 32'(em));
                check($sformatf("%s_k_%0d", tag, n),   32'(bus.k_out),   32'(ek));
            end
            if (mode == 1 && n == 100) begin
                bus.k_wr   = 1'b1;
                bus.k_addr = 5'd3;
                bus.k_data = 16'h1000;
            end
            if (mode == 1 && n >= 200 && n < 250) begin
                bus.pix_valid = 1'b1;
                bus.pix_in    = 16'h7FFF;
            end
            if (mode == 2 && n == 1000) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check({tag, "_rst_ready"},   32'(bus.ready),   32'd1);
                check({tag, "_rst_map_out"}, 32'(bus.map_out), 32'd0);
                check({tag, "_rst_k_out"},   32'(bus.k_out),   32'd0);
                check({tag, "_rst_done"},    32'(bus.done),    32'd0);
                check({tag, "_pre_rst_lows"}, 32'(lows), 32'd1001);
                check({tag, "_pre_rst_bad"},  32'(nbad), 32'd0);
                return;
            end
        end
        check({tag, "_ready_low_cycles"}, 32'(lows), 32'(NPAIRS));
        check({tag, "_pair_mismatches"},  32'(nbad), 32'd0);
        check({tag, "_first_bad_pair"},   32'(first_bad), 32'hFFFF_FFFF);
        check({tag, "_saw_7fff"},         32'(n7fff), 32'd0);
        tick();
        check({tag, "_end_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_end_done"},  32'(bus.done),  32'd1);
        for (int h = 0; h < 3; h++) tick();
        check({tag, "_hold_map"},   32'(bus.map_out), 32'd483);
        check({tag, "_hold_k"},     32'(bus.k_out),   32'd25);
        check({tag, "_hold_ready"}, 32'(bus.ready),   32'd1);
        check({tag, "_hold_done"},  32'(bus.done),    32'd1);
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.k_wr      = 1'b0;
        bus.k_addr    = '0;
        bus.k_data    = '0;

        do_reset("por");
        load_weights();
        load_pixels(1'b0);
        run_stream(0, "s1");

        do_reset("rst2");
        load_pixels(1'b1);
        run_stream(1, "s2");

        do_reset("rst3");
        load_pixels(1'b0);
        run_stream(2, "s3");
        load_pixels(1'b0);
        run_stream(0, "s4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
